// File: rtl/wallace_mult_pkg.sv
// Shared types and carry-save helpers for the 6x6 Wallace multiplier datapath.
package wallace_mult_pkg;
   localparam int OPW    = 6;
   localparam int PW     = 12;
   localparam int IDMAXW = 3;

   typedef logic [OPW-1:0]    operand_t;
   typedef logic [PW-1:0]     product_t;
   typedef logic [IDMAXW-1:0] id_t;

   typedef struct packed {
      logic     valid;
      operand_t a;
      operand_t b;
      id_t      id;
   } s1_t;

   typedef struct packed {
      logic     valid;
      product_t r1;
      product_t r2;
      id_t      id;
   } s2_t;

   function automatic product_t csa_sum(product_t x, product_t y, product_t z);
      return x ^ y ^ z;
   endfunction

   // Bits shifted out of the top are dropped; the product never needs them.
   function automatic product_t csa_carry(product_t x, product_t y, product_t z);
      return ((x & y) | (x & z) | (y & z)) << 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer advances past the winner on a grant.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] valid,
   input  logic            enable,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic            fire
);
   logic [IDW-1:0] ptr_reg;
   logic [IDW-1:0] win;
   logic           found;

   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (int'(ptr_reg) + k) % NREQ;
         if (!found && valid[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   always_comb begin
      grant = '0;
      if (found && enable) grant[win] = 1'b1;
   end

   assign fire     = found & enable;
   assign grant_id = win;

   always_ff @(posedge clk) begin
      if (rst)
         ptr_reg <= '0;
      else if (fire)
         ptr_reg <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
   end
endmodule

// File: rtl/wallace_tree_reduction.sv
// Combinational 6x6 carry-save reduction: six partial-product rows down to two rows r1, r2.
module wallace_tree_reduction
   import wallace_mult_pkg::*;
(
   input  operand_t a,
   input  operand_t b,
   output product_t r1,
   output product_t r2
);
   product_t pp [OPW];
   product_t s0, c0, s1, c1, s2, c2;

   generate
      for (genvar gi = 0; gi < OPW; gi++) begin : g_pp
         assign pp[gi] = b[gi] ? (product_t'(a) << gi) : '0;
      end
   endgenerate

   // 6 rows -> 4 -> 3 -> 2
   assign s0 = csa_sum  (pp[0], pp[1], pp[2]);
   assign c0 = csa_carry(pp[0], pp[1], pp[2]);
   assign s1 = csa_sum  (pp[3], pp[4], pp[5]);
   assign c1 = csa_carry(pp[3], pp[4], pp[5]);
   assign s2 = csa_sum  (s0, c0, s1);
   assign c2 = csa_carry(s0, c0, s1);
   assign r1 = csa_sum  (s2, c2, c1);
   assign r2 = csa_carry(s2, c2, c1);
endmodule

// File: rtl/wallace_mult_scheduler.sv
// Shares one pipelined 6x6 Wallace multiplier among NREQ requesters; tagged responses with backpressure.
module wallace_mult_scheduler #(
   parameter  int NREQ = 4,
   parameter  int OPW  = 6,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*OPW-1:0] req_a,
   input  logic [NREQ*OPW-1:0] req_b,
   output logic [NREQ-1:0]     req_ready,
   output logic                rsp_valid,
   output logic [IDW-1:0]      rsp_id,
   output logic [2*OPW-1:0]    rsp_product,
   input  logic                rsp_ready,
   output logic                busy
);
   import wallace_mult_pkg::*;

   generate
      if (OPW != 6) begin : g_bad_opw
         $error("wallace_mult_scheduler: OPW must be 6");
      end
   endgenerate

   s1_t            s1_reg;
   s2_t            s2_reg;
   logic           out_valid_reg;
   logic [IDW-1:0] out_id_reg;
   product_t       out_product_reg;
   logic [1:0]     count_reg;

   logic           stall, enable, xfer, consume;
   logic [IDW-1:0] win_id;
   operand_t       a_sel, b_sel;
   product_t       r1, r2;

   // A stalled response freezes the whole pipe, bubbles included.
   assign stall   = out_valid_reg & ~rsp_ready;
   assign enable  = ~stall & ~rst;
   assign consume = out_valid_reg & rsp_ready;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk      (clk),
      .rst      (rst),
      .valid    (req_valid),
      .enable   (enable),
      .grant    (req_ready),
      .grant_id (win_id),
      .fire     (xfer)
   );

   assign a_sel = req_a[int'(win_id)*OPW +: OPW];
   assign b_sel = req_b[int'(win_id)*OPW +: OPW];

   wallace_tree_reduction u_wtr (
      .a  (s1_reg.a),
      .b  (s1_reg.b),
      .r1 (r1),
      .r2 (r2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_reg          <= '0;
         s2_reg          <= '0;
         out_valid_reg   <= 1'b0;
         out_id_reg      <= '0;
         out_product_reg <= '0;
         count_reg       <= '0;
      end else begin
         if (!stall) begin
            s1_reg          <= '{valid: xfer, a: a_sel, b: b_sel, id: id_t'(win_id)};
            s2_reg          <= '{valid: s1_reg.valid, r1: r1, r2: r2, id: s1_reg.id};
            out_valid_reg   <= s2_reg.valid;
            out_id_reg      <= s2_reg.id[IDW-1:0];
            out_product_reg <= s2_reg.r1 + s2_reg.r2;
         end
         case ({xfer, consume})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rsp_valid   = out_valid_reg;
   assign rsp_id      = out_id_reg;
   assign rsp_product = out_product_reg;
   assign busy        = (count_reg != 2'd0);
endmodule

// File: tb/tb_wallace_mult_scheduler.sv
// Directed bench for wallace_mult_scheduler: latency, round-robin order, backpressure, reset, full sweep.
module tb_wallace_mult_scheduler;
   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [23:0] req_a;
   logic [23:0] req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [11:0] rsp_product;
   logic        rsp_ready;
   logic        busy;

   int errors = 0;
   int checks = 0;

   wallace_mult_scheduler #(.NREQ(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .rsp_ready   (rsp_ready),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      req_a[i*6 +: 6] = a[5:0];
      req_b[i*6 +: 6] = b[5:0];
   endtask

   task automatic do_reset;
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      settle();
      tick();
      rst = 1'b0;
   endtask

   int exp3 [5] = '{15, 18, 21, 24, 27};
   int expq [$];

   initial begin
      rst       = 1'b1;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      settle();
      check("reset_req_ready", req_ready, 0);
      tick();
      rst       = 1'b0;
      req_valid = '0;
      settle();
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_rsp_product", rsp_product, 0);
      check("reset_rsp_id", rsp_id, 0);

      // Single op, 63*63
      set_op(0, 63, 63);
      req_valid = 4'b0001;
      settle();
      check("t1_grant", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      for (int c = 1; c <= 3; c++) begin
         settle();
         check("t1_busy", busy, 1);
         check("t1_rsp_valid", rsp_valid, (c == 3) ? 1 : 0);
         if (c == 3) begin
            check("t1_product", rsp_product, 3969);
            check("t1_id", rsp_id, 0);
            $display("t1 rsp id=%0d product=%0d", rsp_id, rsp_product);
         end
         tick();
      end
      settle();
      check("t1_idle_busy", busy, 0);
      check("t1_idle_valid", rsp_valid, 0);

      // All requesters valid: rotation 0,1,2,3,0
      do_reset();
      for (int i = 0; i < 4; i++) set_op(i, i + 1, 2);
      for (int c = 0; c < 9; c++) begin
         req_valid = (c < 5) ? 4'hF : 4'h0;
         settle();
         if (c < 5) check("t2_grant", req_ready, 1 << (c % 4));
         if (c >= 3 && c <= 7) begin
            check("t2_rsp_valid", rsp_valid, 1);
            check("t2_rsp_id", rsp_id, (c - 3) % 4);
            check("t2_product", rsp_product, 2 * ((c - 3) % 4 + 1));
            $display("t2 rsp id=%0d product=%0d", rsp_id, rsp_product);
         end else begin
            check("t2_no_rsp", rsp_valid, 0);
         end
         tick();
      end

      // Backpressure: five ops from requester 2, consumer stalls for cycles 4..7
      do_reset();
      begin
         int n = 0;
         int got = 0;
         for (int c = 0; c < 20; c++) begin
            logic took;
            rsp_ready = !(c >= 4 && c <= 7);
            req_valid = (n < 5) ? 4'b0100 : 4'b0000;
            set_op(2, 3, 5 + n);
            settle();
            if (c >= 4 && c <= 7) begin
               check("t3_stall_ready", req_ready, 0);
               check("t3_stall_valid", rsp_valid, 1);
               check("t3_stall_hold", rsp_product, 18);
            end
            took = req_valid[2] & req_ready[2];
            if (rsp_valid && rsp_ready) begin
               if (got < 5) begin
                  check("t3_product", rsp_product, exp3[got]);
                  check("t3_id", rsp_id, 2);
               end else begin
                  check("t3_extra_rsp", rsp_valid, 0);
               end
               $display("t3 rsp id=%0d product=%0d", rsp_id, rsp_product);
               got++;
            end
            tick();
            if (took) n++;
         end
         check("t3_accepted", n, 5);
         check("t3_responses", got, 5);
         rsp_ready = 1'b1;
      end

      // Pointer fairness: grant 1 moves pointer to 2; idle cycles do not move it
      do_reset();
      req_valid = 4'b0010;
      settle();
      check("t4_first_grant", req_ready, 4'b0010);
      tick();
      for (int c = 0; c < 2; c++) begin
         req_valid = '0;
         settle();
         check("t4_idle_ready", req_ready, 0);
         tick();
      end
      req_valid = 4'b1010;
      settle();
      check("t4_grant_3", req_ready, 4'b1000);
      tick();
      settle();
      check("t4_grant_1", req_ready, 4'b0010);
      tick();
      req_valid = '0;

      // Reset mid-flight discards two accepted ops
      do_reset();
      set_op(0, 5, 5);
      set_op(2, 7, 9);
      req_valid = 4'b0001;
      settle();
      tick();
      settle();
      tick();
      rst       = 1'b1;
      req_valid = 4'b1100;
      settle();
      check("t5_rst_ready", req_ready, 0);
      tick();
      rst = 1'b0;
      settle();
      check("t5_busy_after_rst", busy, 0);
      check("t5_no_stale_rsp", rsp_valid, 0);
      check("t5_grant_lowest", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      for (int c = 1; c <= 3; c++) begin
         settle();
         check("t5_rsp_valid", rsp_valid, (c == 3) ? 1 : 0);
         if (c == 3) begin
            check("t5_rsp_id", rsp_id, 2);
            check("t5_product", rsp_product, 63);
            $display("t5 rsp id=%0d product=%0d", rsp_id, rsp_product);
         end
         tick();
      end

      // Exhaustive sweep from requester 0 with random consumer stalls
      do_reset();
      expq.delete();
      begin
         int acc = 0;
         int rsp = 0;
         int cyc = 0;
         while (rsp < 4096 && cyc < 30000) begin
            logic took;
            req_valid = (acc < 4096) ? 4'b0001 : 4'b0000;
            set_op(0, acc >> 6, acc & 63);
            rsp_ready = 1'($urandom_range(0, 1));
            settle();
            took = req_valid[0] & req_ready[0];
            if (rsp_valid && rsp_ready) begin
               if (expq.size() == 0) begin
                  check("t6_spurious_rsp", rsp_valid, 0);
               end else begin
                  check("t6_product", rsp_product, expq.pop_front());
                  check("t6_id", rsp_id, 0);
               end
               $display("t6 rsp id=%0d product=%0d", rsp_id, rsp_product);
               rsp++;
            end
            if (took) expq.push_back((acc >> 6) * (acc & 63));
            tick();
            if (took) acc++;
            cyc++;
         end
         check("t6_accepted", acc, 4096);
         check("t6_responses", rsp, 4096);
         req_valid = '0;
         rsp_ready = 1'b1;
         settle();
         check("t6_busy_end", busy, 0);
         check("t6_queue_empty", expq.size(), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
